// File: rtl/fetch_stage_pkg.sv
// Shared types for the instruction fetch stage: fetch state, fetch->decode payload, PC defaults.
package fetch_stage_pkg;

    typedef enum logic {
        REQ  = 1'b0,
        HOLD = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] raw_instr;
    } fetch_data_t;

    localparam logic [63:0] FETCH_PC_RESET = 64'h8000_0000;
    localparam logic [63:0] FETCH_PC_STEP  = 64'd4;

endpackage

// File: rtl/fetch_stage_skid_buf.sv
// One-entry skid buffer between the instruction bus and the fetch->decode register.
// Only built when FETCH_SKID_EN is defined; the caller guarantees a free slot before pushing.
`ifdef FETCH_SKID_EN
module fetch_skid_buf
    import fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    input  fetch_data_t in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output fetch_data_t out_data
);

    logic accept;

    // A pop and a push in the same cycle leave the entry full with the new word.
    assign accept = in_valid && (!out_valid || out_ready);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            out_data <= in_data;
        end
    end

endmodule
`endif

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, keeps one bus request in flight, feeds decode via valid/ready.
// Optional feature: define FETCH_SKID_EN for a one-entry skid buffer that hides one decode stall.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [63:0] PC_RESET = FETCH_PC_RESET,
    parameter logic [63:0] PC_STEP  = FETCH_PC_STEP
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ireq_valid,
    output logic [63:0] ireq_addr,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    input  logic        redir_valid,
    input  logic [63:0] redir_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_pc,
    output logic [31:0] out_instr
);

    fetch_state_t state, state_nx;
    logic [63:0]  fetch_pc, fetch_pc_nx;
    logic [63:0]  pending_pc, pending_pc_nx;
    logic         drop, drop_nx;
    logic         out_valid_nx;
    fetch_data_t  out_data, out_data_nx;
    fetch_data_t  resp_word;
    logic         out_fire;

`ifdef FETCH_SKID_EN
    logic         skid_valid;
    fetch_data_t  skid_data;
    logic         skid_push;
    logic         skid_pop;
    logic         skid_after;
    logic         take_word;
    logic         word_to_out;

    fetch_skid_buf u_skid (
        .clk       (clk),
        .reset     (reset),
        .flush     (redir_valid),
        .in_valid  (skid_push),
        .in_data   (resp_word),
        .out_valid (skid_valid),
        .out_ready (skid_pop),
        .out_data  (skid_data)
    );
`endif

    // In REQ the request stays up with a fixed address until data_ok, even across a redirect.
    assign ireq_valid = (state == REQ);
    assign ireq_addr  = fetch_pc;
    assign resp_word  = {fetch_pc, iresp_data};
    assign out_fire   = out_valid && out_ready;
    assign out_pc     = out_data.pc;
    assign out_instr  = out_data.raw_instr;

    always_comb begin
        state_nx      = state;
        fetch_pc_nx   = fetch_pc;
        pending_pc_nx = pending_pc;
        drop_nx       = drop;
        out_valid_nx  = out_valid;
        out_data_nx   = out_data;
`ifdef FETCH_SKID_EN
        skid_push     = 1'b0;
        skid_pop      = 1'b0;
        skid_after    = 1'b0;
        take_word     = 1'b0;
        word_to_out   = 1'b0;
`endif
        if (redir_valid) begin
            out_valid_nx = 1'b0;
            if (state == REQ && !iresp_data_ok) begin
                // Request cannot be withdrawn: remember the target and discard its response.
                pending_pc_nx = redir_pc;
                drop_nx       = 1'b1;
            end else begin
                fetch_pc_nx = redir_pc;
                drop_nx     = 1'b0;
                state_nx    = REQ;
            end
        end else if (state == REQ && iresp_data_ok && drop) begin
            fetch_pc_nx = pending_pc;
            drop_nx     = 1'b0;
        end else begin
`ifdef FETCH_SKID_EN
            take_word = (state == REQ) && iresp_data_ok;
            if (take_word) begin
                fetch_pc_nx = fetch_pc + PC_STEP;
            end
            if (!out_valid || out_fire) begin
                if (skid_valid) begin
                    out_valid_nx = 1'b1;
                    out_data_nx  = skid_data;
                    skid_pop     = 1'b1;
                end else if (take_word) begin
                    out_valid_nx = 1'b1;
                    out_data_nx  = resp_word;
                    word_to_out  = 1'b1;
                end else begin
                    out_valid_nx = 1'b0;
                end
            end
            skid_push  = take_word && !word_to_out;
            skid_after = skid_push || (skid_valid && !skid_pop);
            // Only issue another request when its response is guaranteed a free slot.
            if (state == HOLD || take_word) begin
                state_nx = (out_valid_nx && skid_after) ? HOLD : REQ;
            end
`else
            if (state == REQ) begin
                if (iresp_data_ok) begin
                    out_valid_nx = 1'b1;
                    out_data_nx  = resp_word;
                    state_nx     = HOLD;
                end
            end else if (out_fire) begin
                fetch_pc_nx  = fetch_pc + PC_STEP;
                out_valid_nx = 1'b0;
                state_nx     = REQ;
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= REQ;
            fetch_pc  <= PC_RESET;
            drop      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            state     <= state_nx;
            fetch_pc  <= fetch_pc_nx;
            drop      <= drop_nx;
            out_valid <= out_valid_nx;
            out_data  <= out_data_nx;
        end
    end

    // Only meaningful while drop is set, so it carries no reset.
    always_ff @(posedge clk) begin
        pending_pc <= pending_pc_nx;
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage (default build): scoreboard of delivered instructions plus bus-side checks.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    logic        redir_valid;
    logic [63:0] redir_pc;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_instr;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    fetch_stage dut (
        .clk           (clk),
        .reset         (reset),
        .ireq_valid    (ireq_valid),
        .ireq_addr     (ireq_addr),
        .iresp_data_ok (iresp_data_ok),
        .iresp_data    (iresp_data),
        .redir_valid   (redir_valid),
        .redir_pc      (redir_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_pc        (out_pc),
        .out_instr     (out_instr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic respond(input logic [31:0] data);
        iresp_data_ok = 1'b1;
        iresp_data    = data;
        cyc();
        iresp_data_ok = 1'b0;
        iresp_data    = '0;
    endtask

    task automatic push_exp(input logic [63:0] pc, input logic [31:0] instr);
        exp_t e;
        e.pc    = pc;
        e.instr = instr;
        exp_q.push_back(e);
    endtask

    task automatic accept_one();
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
    endtask

    // Monitor: every handshake with decode must match the oldest expected instruction.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready && !redir_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_out: got pc %h instr %h, expected no output", out_pc, out_instr);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_pc", out_pc, e.pc);
                check("out_instr", {32'd0, out_instr}, {32'd0, e.instr});
            end
        end
    end

    initial begin
        reset         = 1'b1;
        iresp_data_ok = 1'b0;
        iresp_data    = '0;
        redir_valid   = 1'b0;
        redir_pc      = '0;
        out_ready     = 1'b0;
        cyc();
        cyc();
        check("rst_ireq_valid", {63'd0, ireq_valid}, 64'd1);
        check("rst_ireq_addr", ireq_addr, 64'h8000_0000);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_pc", out_pc, 64'd0);
        check("rst_out_instr", {32'd0, out_instr}, 64'd0);
        reset = 1'b0;
        cyc();

        // First fetch, then a five-cycle decode stall
        push_exp(64'h8000_0000, 32'h0010_0093);
        respond(32'h0010_0093);
        check("first_out_valid", {63'd0, out_valid}, 64'd1);
        for (int i = 0; i < 5; i++) begin
            check("stall_out_pc", out_pc, 64'h8000_0000);
            check("stall_out_instr", {32'd0, out_instr}, 64'h0010_0093);
            check("stall_ireq_valid", {63'd0, ireq_valid}, 64'd0);
            cyc();
        end
        accept_one();
        check("next_ireq_valid", {63'd0, ireq_valid}, 64'd1);
        check("next_ireq_addr", ireq_addr, 64'h8000_0004);

        push_exp(64'h8000_0004, 32'h0020_0113);
        respond(32'h0020_0113);
        accept_one();
        check("addr_8", ireq_addr, 64'h8000_0008);

        // Redirect while the request to ...0008 is in flight
        redir_valid = 1'b1;
        redir_pc    = 64'h8000_0100;
        cyc();
        redir_valid = 1'b0;
        check("inflight_addr_held", ireq_addr, 64'h8000_0008);
        cyc();
        cyc();
        check("inflight_valid_held", {63'd0, ireq_valid}, 64'd1);
        respond(32'hDEAD_BEEF);
        check("drop_no_out_valid", {63'd0, out_valid}, 64'd0);
        check("drop_next_addr", ireq_addr, 64'h8000_0100);

        // Redirect coinciding with data_ok
        redir_valid   = 1'b1;
        redir_pc      = 64'h8000_0200;
        respond(32'hBAD0_0001);
        redir_valid   = 1'b0;
        check("same_cyc_out_valid", {63'd0, out_valid}, 64'd0);
        check("same_cyc_addr", ireq_addr, 64'h8000_0200);

        // Two redirects while the first discard is pending: only the last target is fetched
        redir_valid = 1'b1;
        redir_pc    = 64'h8000_0300;
        cyc();
        redir_pc    = 64'h8000_0400;
        cyc();
        redir_valid = 1'b0;
        check("double_redir_addr_held", ireq_addr, 64'h8000_0200);
        respond(32'hBAD0_0002);
        check("double_redir_out_valid", {63'd0, out_valid}, 64'd0);
        check("double_redir_addr", ireq_addr, 64'h8000_0400);
        push_exp(64'h8000_0400, 32'h0030_0193);
        respond(32'h0030_0193);
        accept_one();
        check("addr_404", ireq_addr, 64'h8000_0404);

        // Redirect and out_ready together in HOLD: redirect wins, no re-fetch of the held word
        respond(32'h0040_0213);
        check("held_pc_404", out_pc, 64'h8000_0404);
        redir_valid = 1'b1;
        redir_pc    = 64'h8000_0500;
        out_ready   = 1'b1;
        cyc();
        redir_valid = 1'b0;
        out_ready   = 1'b0;
        check("hold_redir_out_valid", {63'd0, out_valid}, 64'd0);
        check("hold_redir_addr", ireq_addr, 64'h8000_0500);
        push_exp(64'h8000_0500, 32'h0050_0293);
        respond(32'h0050_0293);
        accept_one();
        check("addr_504", ireq_addr, 64'h8000_0504);

        // PC wraps at 64 bits
        redir_valid = 1'b1;
        redir_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
        respond(32'hBAD0_0003);
        redir_valid = 1'b0;
        check("wrap_fetch_addr", ireq_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        push_exp(64'hFFFF_FFFF_FFFF_FFFC, 32'h0060_0313);
        respond(32'h0060_0313);
        accept_one();
        check("wrap_next_addr", ireq_addr, 64'd0);

        // Asynchronous reset with a request outstanding
        reset = 1'b1;
        #1;
        check("async_rst_addr", ireq_addr, 64'h8000_0000);
        check("async_rst_out_pc", out_pc, 64'd0);
        check("async_rst_out_valid", {63'd0, out_valid}, 64'd0);
        cyc();
        reset = 1'b0;
        cyc();
        push_exp(64'h8000_0000, 32'h0070_0393);
        respond(32'h0070_0393);
        accept_one();
        check("post_rst_addr", ireq_addr, 64'h8000_0004);
        cyc();
        cyc();
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
